// File: rtl/fp_addsub_normalize.sv
// Back end of the FP add/sub datapath. It fixes up the raw significand
// sum or difference, normalizes it one bit per cycle, rounds to nearest
// even and packs a single-precision result behind a valid/ready handshake.
// One operation is in flight at a time.
module fp_addsub_normalize #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int SUM_W = MAN_W + 5,
    localparam int RES_W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic             in_complement,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIXUP,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    // One extra exponent bit so that a carry past the all-ones code is visible.
    localparam logic [EXP_W:0]   EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [SUM_W-1:0] SUM_ONE = {{(SUM_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic               comp_q, comp_d;
    logic [EXP_W:0]     exp_q, exp_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Fixup and rounding views of the working registers.
    logic [SUM_W-1:0]   fix_mag;
    logic               fix_sign;
    logic [EXP_W:0]     fix_exp;
    logic               round_inc;
    logic [MAN_W+1:0]   rnd_mag;
    logic [EXP_W:0]     rnd_exp;
    logic [MAN_W-1:0]   rnd_frac;

    // Sign/complement correction and RNE rounding, derived from the registers.
    always_comb begin
        fix_mag  = sum_q;
        fix_sign = sign_q;
        fix_exp  = exp_q;
        if (comp_q && sum_q[SUM_W-1]) begin
            fix_mag  = ~sum_q + SUM_ONE;
            fix_sign = ~sign_q;
        end else if (!comp_q && sum_q[SUM_W-1]) begin
            // The bit shifted out of R folds into sticky.
            fix_mag  = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            fix_exp  = exp_q + EXP_ONE;
        end

        // LSB is bit 3, guard bit 2, round bit 1, sticky bit 0.
        round_inc = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        rnd_mag   = sum_q[SUM_W-1:3] + {{(MAN_W+1){1'b0}}, round_inc};
        if (rnd_mag[MAN_W+1]) begin
            rnd_exp  = exp_q + EXP_ONE;
            rnd_frac = rnd_mag[MAN_W:1];
        end else begin
            rnd_exp  = exp_q;
            rnd_frac = rnd_mag[MAN_W-1:0];
        end
    end

    // Next-state and datapath update for the operation FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        sign_d   = sign_q;
        comp_d   = comp_q;
        exp_d    = exp_q;
        sum_d    = sum_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    comp_d  = in_complement;
                    exp_d   = {1'b0, in_exp};
                    sum_d   = in_sum;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                sum_d  = fix_mag;
                sign_d = fix_sign;
                exp_d  = fix_exp;
                if (fix_mag == '0) begin
                    sign_d   = 1'b0;
                    result_d = '0;
                    zero_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (fix_mag[SUM_W-2]) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (exp_q == EXP_ONE) begin
                    // Shifting further would need a denormal: flush to signed zero.
                    result_d = {sign_q, {(RES_W-1){1'b0}}};
                    unf_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    sum_d = {sum_q[SUM_W-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                    if (sum_q[SUM_W-3]) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                exp_d = rnd_exp;
                if (rnd_exp >= EXP_MAX) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            comp_q   <= 1'b0;
            exp_q    <= '0;
            sum_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            sign_q   <= sign_d;
            comp_q   <= comp_d;
            exp_q    <= exp_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready      = rst_n && (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_addsub_normalize.sv
// Directed bench for fp_addsub_normalize: hand-computed results, flags,
// latencies, output back-pressure and reset in the middle of normalization.
module tb_fp_addsub_normalize;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic        in_complement;
    logic [7:0]  in_exp;
    logic [27:0] in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int checks = 0;
    int errors = 0;

    fp_addsub_normalize dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_complement (in_complement),
        .in_exp        (in_exp),
        .in_sum        (in_sum),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one operation; returns once out_valid is seen (or the budget expires).
    task automatic start_op(input logic s, input logic c, input logic [7:0] e,
                            input logic [27:0] sum, output int lat);
        int wait_n = 0;
        while (!in_ready && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_sign       = s;
        in_complement = c;
        in_exp        = e;
        in_sum        = sum;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full operation with result, flag and latency checks, then the handshake.
    task automatic run_op(input string tag, input logic s, input logic c,
                          input logic [7:0] e, input logic [27:0] sum,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags,
                          input int exp_lat);
        int lat;
        start_op(s, c, e, sum, lat);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, out_result, exp_res);
        check({tag, "_flags"}, {29'b0, out_zero, out_overflow, out_underflow},
              {29'b0, exp_flags});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_clear"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_flags_clear"}, {29'b0, out_zero, out_overflow, out_underflow}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_sign       = 1'b0;
        in_complement = 1'b0;
        in_exp        = '0;
        in_sum        = '0;
        out_ready     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", out_result, 32'h0);
        check("reset_flags", {29'b0, out_zero, out_overflow, out_underflow}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);

        // flags are {zero, overflow, underflow}
        run_op("add_1p1",      1'b0, 1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000, 3);
        run_op("sub_1m1",      1'b0, 1'b1, 8'd127, 28'h0000000, 32'h00000000, 3'b100, 2);
        run_op("zero_neg",     1'b1, 1'b1, 8'd127, 28'h0000000, 32'h00000000, 3'b100, 2);
        run_op("sub_1m075",    1'b0, 1'b1, 8'd127, 28'h1000000, 32'h3E800000, 3'b000, 5);
        run_op("sub_075m1",    1'b0, 1'b1, 8'd127, 28'hF000000, 32'hBE800000, 3'b000, 5);
        run_op("rne_tie_even", 1'b0, 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b000, 3);
        run_op("rne_tie_odd",  1'b0, 1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b000, 3);
        run_op("rne_carry",    1'b0, 1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b000, 3);
        run_op("overflow",     1'b0, 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b010, 3);
        run_op("underflow",    1'b0, 1'b1, 8'd3,   28'h0000100, 32'h00000000, 3'b001, 5);
        run_op("underflow_n",  1'b1, 1'b1, 8'd3,   28'h0000100, 32'h80000000, 3'b001, 5);

        // Back-pressure: result held, new requests ignored while DONE.
        start_op(1'b0, 1'b0, 8'd127, 28'h8000000, lat);
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        held = out_result;
        check("hold_first", held, 32'h40000000);
        for (int i = 0; i < 4; i++) begin
            in_valid      = (i == 1);
            in_complement = 1'b1;
            in_sum        = 28'h0000000;
            @(posedge clk); #1;
            check("hold_result", out_result, 32'h40000000);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", {31'b0, out_valid}, 32'd0);
        check("hold_not_captured", {31'b0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle_valid", {31'b0, out_valid}, 32'd0);

        // Reset while normalizing a long shift chain.
        in_sign       = 1'b0;
        in_complement = 1'b1;
        in_exp        = 8'd100;
        in_sum        = 28'h0000100;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_in_ready", {31'b0, in_ready}, 32'd0);
        check("midreset_result", out_result, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("postreset_in_ready", {31'b0, in_ready}, 32'd1);
        check("postreset_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        run_op("after_reset",  1'b0, 1'b1, 8'd127, 28'h1000000, 32'h3E800000, 3'b000, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
